// File: rtl/ifu_pkg.sv
// Shared CPU widths, IFU state encodings and the NOP word used by the fetch unit.
package ifu_pkg;

    localparam int CPU_ADDR_WIDTH  = 32;
    localparam int CPU_INSTR_WIDTH = 32;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2
    } ifu_state_e;

    localparam logic [CPU_INSTR_WIDTH-1:0] IFU_NOP = '0;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding bus read engine behind the fetch stage.
// Optional one-entry last-address hit buffer enabled by `CPU_IFU_LASTHIT_EN.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   IFU_IDLE | waiting for a read command
//   IFU_REQ  | bus request asserted, waiting for i_bus_cmd_accept
//   IFU_WAIT | request accepted, waiting for i_bus_resp
module ifu
    import ifu_pkg::*;
(
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [CPU_ADDR_WIDTH-1:0]  i_addr,
    input  logic                       i_rd_cmd,
    output logic [CPU_INSTR_WIDTH-1:0] o_instr_dat,
    output logic                       o_busy,
    output logic                       o_err_align,
    output logic                       o_err_bus,
    output logic [CPU_ADDR_WIDTH-1:0]  o_bus_addr,
    output logic                       o_bus_cmd,
    input  logic                       i_bus_cmd_accept,
    input  logic [CPU_INSTR_WIDTH-1:0] i_bus_rdata,
    input  logic                       i_bus_resp,
    input  logic                       i_bus_resp_err
);

    ifu_state_e                state_q;
    ifu_state_e                state_d;
    logic [CPU_ADDR_WIDTH-1:0] addr_q;
    logic                      aligned;
    logic                      hit;
    logic                      cmd_take;
    logic                      resp_take;

    assign aligned   = (i_addr[1:0] == 2'b00);
    assign cmd_take  = (state_q == IFU_IDLE) && i_rd_cmd;
    assign resp_take = (state_q == IFU_WAIT) && i_bus_resp;

`ifdef CPU_IFU_LASTHIT_EN
    logic                      hit_valid;
    logic [CPU_ADDR_WIDTH-1:0] hit_addr;

    // The buffered data is o_instr_dat itself; only the address is stored here.
    assign hit = hit_valid && (hit_addr == i_addr);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hit_valid <= 1'b0;
            hit_addr  <= '0;
        end else if (cmd_take && !aligned) begin
            hit_valid <= 1'b0;
        end else if (resp_take) begin
            if (i_bus_resp_err) begin
                hit_valid <= 1'b0;
            end else begin
                hit_valid <= 1'b1;
                hit_addr  <= addr_q;
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IFU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Busy has a combinational term so the fetch stage sees it in its command cycle.
    always_comb begin
        state_d   = state_q;
        o_bus_cmd = 1'b0;
        o_busy    = (state_q != IFU_IDLE) || (i_rd_cmd && aligned && !hit);
        case (state_q)
            IFU_IDLE: begin
                if (i_rd_cmd && aligned && !hit) begin
                    state_d = IFU_REQ;
                end
            end
            IFU_REQ: begin
                o_bus_cmd = 1'b1;
                if (i_bus_cmd_accept) begin
                    state_d = IFU_WAIT;
                end
            end
            IFU_WAIT: begin
                if (i_bus_resp) begin
                    state_d = IFU_IDLE;
                end
            end
            default: state_d = IFU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            addr_q      <= '0;
            o_instr_dat <= IFU_NOP;
            o_err_align <= 1'b0;
            o_err_bus   <= 1'b0;
        end else if (cmd_take) begin
            addr_q      <= i_addr;
            o_err_align <= !aligned;
            o_err_bus   <= 1'b0;
            if (!aligned) begin
                o_instr_dat <= IFU_NOP;
            end
        end else if (resp_take) begin
            if (i_bus_resp_err) begin
                o_instr_dat <= IFU_NOP;
                o_err_bus   <= 1'b1;
            end else begin
                o_instr_dat <= i_bus_rdata;
            end
        end
    end

    assign o_bus_addr = addr_q;

endmodule
